// File: rtl/half_adder_pkg.sv
// rtl/half_adder_pkg.sv - shared constants for the registered word-level half adder
package half_adder_pkg;

  localparam int HA_DEFAULT_WIDTH = 20;

endpackage

// File: rtl/half_adder_cell.sv
// rtl/half_adder_cell.sv - single-bit combinational half-adder cell
module half_adder_cell (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/half_adder.sv
// rtl/half_adder.sv - registered ripple-carry add of two unsigned words, no carry-in
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH = HA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             out_valid
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH:1]   carry;

  // carry[i] is the carry into bit i; carry[WIDTH] is the word carry-out
  half_adder_cell u_bit0 (
    .x (a[0]),
    .y (b[0]),
    .s (sum[0]),
    .c (carry[1])
  );

  for (genvar i = 1; i < WIDTH; i++) begin : g_full_add
    logic s_lo;
    logic c_lo;
    logic c_hi;

    half_adder_cell u_lo (
      .x (a[i]),
      .y (b[i]),
      .s (s_lo),
      .c (c_lo)
    );

    half_adder_cell u_hi (
      .x (s_lo),
      .y (carry[i]),
      .s (sum[i]),
      .c (c_hi)
    );

    assign carry[i+1] = c_lo | c_hi;
  end

  // Result registers load only on in_valid so idle-cycle operand values never reach them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out  <= sum;
        cout <= carry[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_half_adder.sv
// tb/tb_half_adder.sv - randomized self-checking bench for half_adder at WIDTH=20 and WIDTH=1
module tb_half_adder;

  localparam int W = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] out;
  logic         cout;
  logic         out_valid;
  logic         a1 = 1'b0;
  logic         b1 = 1'b0;
  logic         out1;
  logic         cout1;
  logic         out_valid1;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_out   = '0;
  logic         exp_cout  = 1'b0;
  logic         exp_valid = 1'b0;
  logic         exp_out1  = 1'b0;
  logic         exp_cout1 = 1'b0;

  half_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out       (out),
    .cout      (cout),
    .out_valid (out_valid)
  );

  half_adder #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a1),
    .b         (b1),
    .out       (out1),
    .cout      (cout1),
    .out_valid (out_valid1)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".out"},        64'(out),        64'(exp_out));
    check_eq({tag, ".cout"},       64'(cout),       64'(exp_cout));
    check_eq({tag, ".out_valid"},  64'(out_valid),  64'(exp_valid));
    check_eq({tag, ".w1.out"},     64'(out1),       64'(exp_out1));
    check_eq({tag, ".w1.cout"},    64'(cout1),      64'(exp_cout1));
    check_eq({tag, ".w1.valid"},   64'(out_valid1), 64'(exp_valid));
  endtask

  // Drives one cycle from #1 after an edge, then checks the result #1 after the next edge
  task automatic drive_cycle(input string tag, input logic v, input logic [W-1:0] va,
                             input logic [W-1:0] vb, input logic v1a, input logic v1b);
    longint unsigned total;
    int              total1;
    in_valid = v;
    a        = va;
    b        = vb;
    a1       = v1a;
    b1       = v1b;
    @(posedge clk);
    #1;
    if (v) begin
      total     = longint'(va) + longint'(vb);
      exp_out   = W'(total % (64'd1 << W));
      exp_cout  = (total >= (64'd1 << W));
      total1    = int'(v1a) + int'(v1b);
      exp_out1  = (total1 % 2) == 1;
      exp_cout1 = (total1 / 2) == 1;
    end
    exp_valid = v;
    check_all(tag);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    drive_cycle("w1_00", 1'b1, 20'h00001, 20'h00002, 1'b0, 1'b0);
    drive_cycle("w1_01", 1'b1, 20'h12345, 20'h54321, 1'b0, 1'b1);
    drive_cycle("w1_10", 1'b1, 20'h80000, 20'h80000, 1'b1, 1'b0);
    drive_cycle("w1_11", 1'b1, 20'h7FFFF, 20'h00001, 1'b1, 1'b1);

    drive_cycle("zero_plus_max", 1'b1, 20'h00000, 20'hFFFFF, 1'b0, 1'b1);
    drive_cycle("full_ripple",   1'b1, 20'hFFFFF, 20'h00001, 1'b1, 1'b0);
    drive_cycle("max_plus_max",  1'b1, 20'hFFFFF, 20'hFFFFF, 1'b1, 1'b1);

    drive_cycle("pulse", 1'b1, 20'hABCDE, 20'h6789A, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive_cycle("idle_hold", 1'b0, W'($urandom()), W'($urandom()), 1'($urandom()), 1'($urandom()));
    end

    drive_cycle("pre_reset", 1'b1, 20'hFFFF0, 20'h00123, 1'b1, 1'b1);
    in_valid = 1'b1;
    a        = 20'h11111;
    b        = 20'h22222;
    #2;
    rst       = 1'b1;
    exp_out   = '0;
    exp_cout  = 1'b0;
    exp_valid = 1'b0;
    exp_out1  = 1'b0;
    exp_cout1 = 1'b0;
    #1;
    check_all("async_reset");
    @(posedge clk);
    #1;
    check_all("reset_held");
    rst = 1'b0;
    drive_cycle("after_reset", 1'b0, 20'h33333, 20'h44444, 1'b1, 1'b1);

    for (int i = 0; i < 300; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom());
      rb = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom());
      drive_cycle("random", ($urandom_range(0, 3) != 0), ra, rb, 1'($urandom()), 1'($urandom()));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/half_adder.md
HALF_ADDER -- requirements
Module: half_adder

Interface
REQ-001 Parameter WIDTH, default 20: operand and sum width in bits; legal range 1..64.
REQ-002 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1: reset, asynchronous, active-high.
REQ-004 Port in_valid  input  1: qualifies a and b in the current cycle.
REQ-005 Port a  input  WIDTH: unsigned addend.
REQ-006 Port b  input  WIDTH: unsigned addend.
REQ-007 Port out  output  WIDTH: registered sum, (a+b) mod 2^WIDTH.
REQ-008 Port cout  output  1: registered carry-out of the most significant bit.
REQ-009 Port out_valid  output  1: high for exactly one cycle per accepted operand pair.
REQ-010 The block SHALL have one clock; reset is asynchronous and active-high.

Function
REQ-011 The block SHALL compute {cout,out} = a + b with no carry-in (a word-level half add).
- Unsigned arithmetic; the result is WIDTH+1 bits wide.
- No saturation; wrap-around is reported via cout.
REQ-012 Latency SHALL be exactly 1 cycle: operands sampled at edge N with in_valid=1 appear on out/cout with out_valid=1 after edge N.
REQ-013 Throughput SHALL be one operation per cycle; back-to-back in_valid pulses produce back-to-back results.
- No backpressure and no ready signal.
REQ-014 When in_valid=0 at an edge, out and cout SHALL hold their previous values and out_valid SHALL be 0 after that edge.
REQ-015 The adder SHALL be a ripple chain: bit 0 is a half-adder cell, and bits 1..WIDTH-1 are full adders each built from two half-adder cells plus an OR of their carries.
REQ-016 For WIDTH=1 the block SHALL reduce to a registered single half adder: out=a^b, cout=a&b.
REQ-017 X or Z on a or b while in_valid=0 SHALL NOT affect out, cout or out_valid.

Reset
REQ-018 While rst=1, out, cout and out_valid SHALL be 0, immediately and without waiting for a clock edge.
REQ-019 Reset asserted mid-operation SHALL discard the in-flight result; out_valid SHALL NOT assert for operands sampled in the cycle reset was asserted.
REQ-020 The first edge after rst deasserts SHALL sample inputs normally.

Structure
REQ-021 A shared package SHALL hold the default width constant (20) and no typedefs.
REQ-022 One sub-module, half_adder_cell, SHALL be used:
- Ports: x, y, s, c.
- Behaviour: s = x^y, c = x&y.
- It is purely combinational; all registers live in half_adder.

Verification
REQ-023 WIDTH=1, apply in_valid=1 with (a,b) = (0,0), (0,1), (1,0), (1,1) on consecutive cycles:
- Results (out,cout) = (0,0), (1,0), (1,0), (0,1).
- Each result is valid one cycle after its inputs.
REQ-024 WIDTH=20, a=20'h00000, b=20'hFFFFF -> out=20'hFFFFF, cout=0.
REQ-025 WIDTH=20, a=20'hFFFFF, b=20'h00001 -> out=20'h00000, cout=1 (full carry ripple).
REQ-026 WIDTH=20, a=20'hFFFFF, b=20'hFFFFF -> out=20'hFFFFE, cout=1.
REQ-027 in_valid pulse, then 3 idle cycles -> out_valid high for 1 cycle only, and out/cout stay held through the idle cycles.
REQ-028 Assert rst asynchronously between edges right after an in_valid cycle:
- out, cout and out_valid go to 0 immediately.
- No valid result is emitted after rst deasserts.
